// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the counter_bank block.
// Optional feature macro: COUNTER_BANK_EDGE_EN (per-channel edge/level mode).
package counter_bank_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_NUM_CHANNELS = 8;
  localparam int unsigned DEFAULT_RESOLUTION   = 32;
  localparam int unsigned DEFAULT_WORD_WIDTH   = 1;

  // Low bit of channel idx inside a bus packed at width bits per channel.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/counter_bank_if.sv
// Snapshot readout bus of counter_bank: packed counts, overflow flags and a
// valid/ready handshake. The bank is the master, the readout path the slave.
interface counter_bank_if
  import counter_bank_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
  parameter int unsigned RESOLUTION   = DEFAULT_RESOLUTION
);

  logic [NUM_CHANNELS*RESOLUTION-1:0] counts_out;
  logic [NUM_CHANNELS-1:0]            overflow;
  logic                               out_valid;
  logic                               out_ready;

  modport master (
    output counts_out,
    output overflow,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  counts_out,
    input  overflow,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/counter_bank_channel.sv
// One counter_bank channel: event detect, saturating counter and
// overflow-pending bit. count_next/pending_next already include this cycle's
// event so the top can snapshot them on a terminal cycle.
// With COUNTER_BANK_EDGE_EN defined, mode selects level (1) or edge (0)
// detection and a prev register is built; otherwise every channel is level.
module counter_bank_channel
  import counter_bank_pkg::*;
#(
  parameter int unsigned RESOLUTION = DEFAULT_RESOLUTION,
  parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  run,
  input  logic                  mode,
  input  logic [WORD_WIDTH-1:0] signal,
  input  logic [RESOLUTION-1:0] counter_max,
  output logic [RESOLUTION-1:0] count_next,
  output logic                  pending_next
);

  logic [RESOLUTION-1:0] count_q;
  logic                  pending_q;
  logic                  event_hit;

`ifdef COUNTER_BANK_EDGE_EN
  logic [WORD_WIDTH-1:0] prev_q;

  // Previous signal word, tracked in every state so edges across IDLE->RUN are seen.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= '0;
    else       prev_q <= signal;
  end

  assign event_hit = (signal != '0) && (mode || (signal != prev_q));
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign event_hit   = (signal != '0);
`endif

  // Saturating increment; an event at saturation marks the window as overflowed.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    count_next   = count_q;
    pending_next = pending_q;
    if (run && event_hit) begin
      if (count_q < counter_max) count_next   = count_q + RESOLUTION'(1);
      else                       pending_next = 1'b1;
    end
  end

  // Counter and pending bit; clear wins so a new window starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else if (clear) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_next;
      pending_q <= pending_next;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// counter_bank top: run/idle FSM, window timer, snapshot register with
// valid/ready handshake, and NUM_CHANNELS counter_bank_channel instances.
// Optional feature macro: COUNTER_BANK_EDGE_EN (per-channel edge/level mode).
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
  parameter int unsigned RESOLUTION   = DEFAULT_RESOLUTION,
  parameter int unsigned WORD_WIDTH   = DEFAULT_WORD_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [RESOLUTION-1:0]              window_len,
  input  logic [RESOLUTION-1:0]              counter_max,
  input  logic [NUM_CHANNELS-1:0]            cumulative,
  input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] signal,
  counter_bank_if.master                     bus,
  output logic                               lost,
  output logic                               busy
);

  state_t                             state_q, state_d;
  logic [RESOLUTION-1:0]              window_q;
  logic [RESOLUTION-1:0]              timer_q;
  logic                               terminal;
  logic                               snap_load;
  logic                               ch_clear;
  logic                               ch_run;
  logic [NUM_CHANNELS*RESOLUTION-1:0] count_next_all;
  logic [NUM_CHANNELS-1:0]            pending_next_all;

  // Window length 0 disables automatic window ends; only flushes snapshot then.
  assign terminal = (window_q != '0) && (timer_q == window_q - RESOLUTION'(1));
  assign busy     = (state_q == ST_RUN);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and channel controls; a flush is a terminal cycle that counts nothing.
  always_comb begin
    state_d   = state_q;
    ch_run    = 1'b0;
    ch_clear  = 1'b0;
    snap_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ch_clear = 1'b1;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          snap_load = 1'b1;
          ch_clear  = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          ch_run = 1'b1;
          if (terminal) begin
            snap_load = 1'b1;
            ch_clear  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Window length latch and cycle timer; timer restarts right after each terminal cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_q <= '0;
      timer_q  <= '0;
    end else if (state_q == ST_IDLE) begin
      timer_q <= '0;
      if (enable) window_q <= window_len;
    end else if (ch_run) begin
      timer_q <= terminal ? '0 : timer_q + RESOLUTION'(1);
    end
  end

  // Snapshot register: load when the slot is free or being accepted, else drop and flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.counts_out <= '0;
      bus.overflow   <= '0;
      bus.out_valid  <= 1'b0;
      lost           <= 1'b0;
    end else if (snap_load) begin
      if (!bus.out_valid || bus.out_ready) begin
        bus.counts_out <= count_next_all;
        bus.overflow   <= pending_next_all;
        bus.out_valid  <= 1'b1;
      end else begin
        lost <= 1'b1;
      end
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    counter_bank_channel #(
      .RESOLUTION (RESOLUTION),
      .WORD_WIDTH (WORD_WIDTH)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .clear        (ch_clear),
      .run          (ch_run),
      .mode         (cumulative[c]),
      .signal       (signal[slice_lo(c, WORD_WIDTH) +: WORD_WIDTH]),
      .counter_max  (counter_max),
      .count_next   (count_next_all[slice_lo(c, RESOLUTION) +: RESOLUTION]),
      .pending_next (pending_next_all[c])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// Directed self-checking bench for counter_bank (8 channels, 32-bit counters,
// 4-bit signal words). Inputs change 1 time unit after the rising edge and
// outputs are checked at that same point.
module tb_counter_bank;

  localparam int NC  = 8;
  localparam int RES = 32;
  localparam int WW  = 4;
  localparam int CW  = NC * RES;
  localparam int SW  = NC * WW;

`ifdef COUNTER_BANK_EDGE_EN
  localparam int EDGE_EXP = 3;
`else
  localparam int EDGE_EXP = 5;
`endif

  logic          clk         = 1'b0;
  logic          reset       = 1'b1;
  logic          enable      = 1'b0;
  logic [RES-1:0] window_len = '0;
  logic [RES-1:0] counter_max = '0;
  logic [NC-1:0] cumulative  = '1;
  logic [SW-1:0] signal      = '0;
  logic          lost;
  logic          busy;

  int tests = 0;
  int fails = 0;

  counter_bank_if #(.NUM_CHANNELS(NC), .RESOLUTION(RES)) bus ();

  counter_bank #(
    .NUM_CHANNELS (NC),
    .RESOLUTION   (RES),
    .WORD_WIDTH   (WW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .window_len  (window_len),
    .counter_max (counter_max),
    .cumulative  (cumulative),
    .signal      (signal),
    .bus         (bus),
    .lost        (lost),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cv(input int ch, input logic [RES-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    r[ch*RES +: RES] = v;
    return r;
  endfunction

  function automatic logic [SW-1:0] sig_of(input int ch, input logic [WW-1:0] v);
    logic [SW-1:0] r;
    r = '0;
    r[ch*WW +: WW] = v;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [WW-1:0] seq [6];
    int rises;
    seq = '{4'd3, 4'd3, 4'd5, 4'd0, 4'd5, 4'd5};

    // Reset values
    bus.out_ready = 1'b0;
    tick(2);
    check("reset_counts", bus.counts_out, '0);
    check("reset_overflow", bus.overflow, '0);
    check("reset_valid", bus.out_valid, 1'b0);
    check("reset_lost", lost, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    tick(1);

    // Level mode, ch0 held high, 10-cycle windows
    window_len    = 10;
    counter_max   = 100;
    cumulative    = '1;
    signal        = sig_of(0, 1);
    bus.out_ready = 1'b1;
    enable        = 1'b1;
    tick(1);
    check("lvl_busy_rise", busy, 1'b1);
    check("lvl_valid_idle", bus.out_valid, 1'b0);
    tick(9);
    check("lvl_no_early_valid", bus.out_valid, 1'b0);
    tick(1);
    check("lvl_win1_valid", bus.out_valid, 1'b1);
    check("lvl_win1_counts", bus.counts_out, cv(0, 10));
    check("lvl_win1_ovf", bus.overflow, '0);
    tick(9);
    check("lvl_gap_valid", bus.out_valid, 1'b0);
    tick(1);
    check("lvl_win2_valid", bus.out_valid, 1'b1);
    check("lvl_win2_counts", bus.counts_out, cv(0, 10));
    signal = '0;
    enable = 1'b0;
    tick(1);
    check("lvl_flush_busy", busy, 1'b0);
    check("lvl_flush_valid", bus.out_valid, 1'b1);
    check("lvl_flush_counts", bus.counts_out, '0);
    tick(1);
    check("lvl_flush_accepted", bus.out_valid, 1'b0);

    // Edge mode on ch1 (level count when edge support is not built)
    cumulative = 8'b1111_1101;
    enable     = 1'b1;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      signal = sig_of(1, seq[i]);
      tick(1);
    end
    signal = '0;
    tick(3);
    check("edge_no_early_valid", bus.out_valid, 1'b0);
    tick(1);
    check("edge_valid", bus.out_valid, 1'b1);
    check("edge_counts", bus.counts_out, cv(1, EDGE_EXP));
    enable = 1'b0;
    tick(2);
    cumulative = '1;

    // Saturation at counter_max=4, then an empty window
    counter_max = 4;
    signal      = sig_of(2, 1);
    enable      = 1'b1;
    tick(11);
    check("sat_counts", bus.counts_out, cv(2, 4));
    check("sat_overflow", bus.overflow, 8'h04);
    signal = '0;
    tick(10);
    check("sat_next_valid", bus.out_valid, 1'b1);
    check("sat_next_counts", bus.counts_out, '0);
    check("sat_next_overflow", bus.overflow, '0);
    enable = 1'b0;
    tick(2);

    // Back-pressure: hold, load-with-accept, then discard
    counter_max   = 100;
    window_len    = 5;
    bus.out_ready = 1'b0;
    signal        = sig_of(0, 1);
    enable        = 1'b1;
    tick(6);
    check("bp_first_valid", bus.out_valid, 1'b1);
    check("bp_first_counts", bus.counts_out, cv(0, 5));
    signal = sig_of(3, 1);
    tick(4);
    check("bp_hold_valid", bus.out_valid, 1'b1);
    check("bp_hold_counts", bus.counts_out, cv(0, 5));
    bus.out_ready = 1'b1;
    tick(1);
    check("bp_swap_valid", bus.out_valid, 1'b1);
    check("bp_swap_counts", bus.counts_out, cv(3, 5));
    check("bp_swap_lost", lost, 1'b0);
    bus.out_ready = 1'b0;
    signal        = sig_of(0, 1);
    tick(5);
    check("bp_drop_counts", bus.counts_out, cv(3, 5));
    check("bp_drop_lost", lost, 1'b1);
    tick(5);
    check("bp_drop2_counts", bus.counts_out, cv(3, 5));
    enable = 1'b0;
    tick(1);
    check("bp_flush_busy", busy, 1'b0);
    check("bp_flush_counts", bus.counts_out, cv(3, 5));
    bus.out_ready = 1'b1;
    tick(1);
    check("bp_drain_valid", bus.out_valid, 1'b0);

    // window_len=0: only the flush produces a snapshot
    window_len = 0;
    signal     = sig_of(0, 1);
    enable     = 1'b1;
    tick(8);
    check("nowin_no_valid", bus.out_valid, 1'b0);
    check("nowin_busy", busy, 1'b1);
    enable = 1'b0;
    tick(1);
    check("nowin_flush_valid", bus.out_valid, 1'b1);
    check("nowin_flush_counts", bus.counts_out, cv(0, 7));
    check("nowin_flush_busy", busy, 1'b0);
    tick(1);
    rises = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (bus.out_valid) rises++;
    end
    check("nowin_no_more_valid", rises, 0);

    // Asynchronous reset mid-window with a pending snapshot
    window_len    = 10;
    bus.out_ready = 1'b0;
    enable        = 1'b1;
    tick(11);
    check("rst_pre_valid", bus.out_valid, 1'b1);
    check("rst_pre_counts", bus.counts_out, cv(0, 10));
    check("rst_pre_lost", lost, 1'b1);
    tick(3);
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("rst_async_counts", bus.counts_out, '0);
    check("rst_async_valid", bus.out_valid, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_lost", lost, 1'b0);
    check("rst_async_ovf", bus.overflow, '0);
    tick(1);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    enable        = 1'b1;
    tick(1);
    check("rst_restart_busy", busy, 1'b1);
    tick(10);
    check("rst_restart_valid", bus.out_valid, 1'b1);
    check("rst_restart_counts", bus.counts_out, cv(0, 10));
    enable = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
